// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_dac_tx
// Purpose  : I2S DAC transmitter. Generates BCLK/LRCK/SDATA from clk and sends
//            one held 24-bit mono sample MSB-first on both channels per frame.
// Revision : 1.0  initial release
// ============================================================================
module i2s_dac_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dac_data,
    input  logic        dac_valid,
    output logic        dac_ready,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        underrun
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_cnt_nxt;
    logic [4:0]       slot_pos;
    logic [4:0]       data_idx;
    logic [23:0]      hold;
    logic             hold_full;
    logic [23:0]      frame_reg;
    logic             div_wrap;
    logic             fall_tick;
    logic             frame_start;
    logic             accept;
    logic             sdata_nxt;
    logic             unused_upper;

    assign unused_upper = ^dac_data[31:24];

    assign dac_ready   = ~hold_full;
    assign accept      = dac_valid & ~hold_full;
    assign div_wrap    = (div_cnt == DIV_LAST);
    assign fall_tick   = div_wrap & bclk;
    assign frame_start = fall_tick & (bit_cnt == 6'd63);
    assign bit_cnt_nxt = bit_cnt + 6'd1;
    assign slot_pos    = bit_cnt_nxt[4:0];
    assign data_idx    = 5'd24 - slot_pos;

    // Data bit for the slot position that becomes current on this fall tick;
    // position 0 is the one-BCLK I2S delay, 25..31 are zero padding.
    always_comb begin
        sdata_nxt = 1'b0;
        if ((slot_pos >= 5'd1) && (slot_pos <= 5'd24)) begin
            sdata_nxt = frame_reg[data_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 6'd0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
        end else if (fall_tick) begin
            bit_cnt <= bit_cnt_nxt;
            lrck    <= bit_cnt_nxt[5];
            sdata   <= sdata_nxt;
        end
    end

    // A word accepted on the frame-start cycle always lands in hold, so an
    // empty hold at frame start still repeats the previous frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= 24'd0;
            hold_full <= 1'b0;
            frame_reg <= 24'd0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_start) begin
                if (hold_full) begin
                    frame_reg <= hold;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (accept) begin
                hold      <= dac_data[23:0];
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
